// File: rtl/ecc_secded_dec_pipe_if.sv
// Valid/ready bus bundle for the pipelined SECDED decoder: codeword input,
// decoded word output and the error-event counter controls.
interface ecc_secded_dec_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PAR_W  = 6,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned CW = DATA_W + PAR_W + 1;

    logic              i_vld;
    logic              i_rdy;
    logic [CW-1:0]     i_code;
    logic              corr_en;
    logic              o_vld;
    logic              o_rdy;
    logic [DATA_W-1:0] o_data;
    logic              o_sec;
    logic              o_ded;
    logic [PAR_W-1:0]  o_syn;
    logic              cnt_clr;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ded_cnt;

    // Decoder side
    modport slave (
        input  i_vld, i_code, corr_en, o_rdy, cnt_clr,
        output i_rdy, o_vld, o_data, o_sec, o_ded, o_syn, sec_cnt, ded_cnt
    );

    // Producer/consumer side
    modport master (
        output i_vld, i_code, corr_en, o_rdy, cnt_clr,
        input  i_rdy, o_vld, o_data, o_sec, o_ded, o_syn, sec_cnt, ded_cnt
    );
endinterface

// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage SECDED Hamming decoder with valid/ready flow control.
// Stage 1 captures the raw word, its syndrome and overall parity; stage 2
// classifies, optionally corrects, extracts data and feeds the event counters.
module ecc_secded_dec_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PAR_W  = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ecc_secded_dec_pipe_if.slave bus
);
    localparam int unsigned N  = DATA_W + PAR_W;
    localparam int unsigned CW = N + 1;

    // Check bits must be able to address every codeword position
    if ((2 ** PAR_W) < (DATA_W + PAR_W + 1)) begin : g_bad_par_w
        $error("ecc_secded_dec_pipe: PAR_W too small for DATA_W");
    end

    logic              en1;
    logic              en2;
    logic              s1_vld;
    logic [CW-1:0]     s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par;
    logic              s1_corr;
    logic              o_vld_q;
    logic [DATA_W-1:0] o_data_q;
    logic              o_sec_q;
    logic              o_ded_q;
    logic [PAR_W-1:0]  o_syn_q;
    logic [CNT_W-1:0]  sec_q;
    logic [CNT_W-1:0]  ded_q;
    logic [PAR_W-1:0]  syn_c;
    logic              par_c;
    logic [CW-1:0]     fix_c;
    logic [DATA_W-1:0] data_c;
    logic              sec_c;
    logic              ded_c;
    logic              hs_c;

    // A stage advances when its downstream slot is free or being emptied
    assign en2   = ~o_vld_q | bus.o_rdy;
    assign en1   = ~s1_vld | en2;
    assign hs_c  = o_vld_q & bus.o_rdy;

    assign bus.i_rdy   = en1;
    assign bus.o_vld   = o_vld_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_sec   = o_sec_q;
    assign bus.o_ded   = o_ded_q;
    assign bus.o_syn   = o_syn_q;
    assign bus.sec_cnt = sec_q;
    assign bus.ded_cnt = ded_q;

    // Syndrome is the XOR of the indices of all set Hamming positions
    always_comb begin
        syn_c = '0;
        for (int unsigned p = 1; p <= N; p++) begin
            if (bus.i_code[p]) begin
                syn_c = syn_c ^ PAR_W'(p);
            end
        end
        par_c = ^bus.i_code;
    end

    // Stage 1: capture the word with its syndrome, parity and correction mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_code <= '0;
            s1_syn  <= '0;
            s1_par  <= 1'b0;
            s1_corr <= 1'b0;
        end else begin
            if (en1) begin
                s1_vld <= bus.i_vld;
            end
            if (en1 && bus.i_vld) begin
                s1_code <= bus.i_code;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
                s1_corr <= bus.corr_en;
            end
        end
    end

    // Classify the error, flip the faulty position if allowed, then gather data bits
    always_comb begin
        int unsigned k;
        fix_c  = s1_code;
        sec_c  = 1'b0;
        ded_c  = 1'b0;
        data_c = '0;
        k      = 0;
        if (s1_par) begin
            if (s1_syn <= PAR_W'(N)) begin
                sec_c = 1'b1;
                if ((s1_syn != '0) && s1_corr) begin
                    fix_c[s1_syn] = ~s1_code[s1_syn];
                end
            end else begin
                ded_c = 1'b1;
            end
        end else if (s1_syn != '0) begin
            ded_c = 1'b1;
        end
        for (int unsigned p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k < DATA_W) begin
                    data_c[k] = fix_c[p];
                end
                k = k + 1;
            end
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
            o_sec_q  <= 1'b0;
            o_ded_q  <= 1'b0;
            o_syn_q  <= '0;
        end else begin
            if (en2) begin
                o_vld_q <= s1_vld;
            end
            if (en2 && s1_vld) begin
                o_data_q <= data_c;
                o_sec_q  <= sec_c;
                o_ded_q  <= ded_c;
                o_syn_q  <= s1_syn;
            end
        end
    end

    // Saturating event counters, bumped once per delivered word; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q <= '0;
            ded_q <= '0;
        end else if (bus.cnt_clr) begin
            sec_q <= '0;
            ded_q <= '0;
        end else if (hs_c) begin
            if (o_sec_q && (sec_q != '1)) begin
                sec_q <= sec_q + CNT_W'(1);
            end
            if (o_ded_q && (ded_q != '1)) begin
                ded_q <= ded_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/ecc_secded_dec_pipe.md
Name: ecc_secded_dec_pipe

Overview:
- Parametrised, pipelined SECDED Hamming decoder. Successor to the fixed 38->32 single-error combinational decoder.
- Adds: any data width, overall-parity double-error detection, a correction enable, valid/ready flow control with a 2-stage pipeline, and saturating SEC/DED event counters.
- Sits between memory/OTP readout and the digital consumer of corrected words.

Parameters:
- DATA_W, 32, data bits per word.
- PAR_W, 6, Hamming check bits. Must satisfy 2^PAR_W >= DATA_W+PAR_W+1; elaboration error otherwise.
- CNT_W, 16, width of each error event counter.
- Derived (localparam): N = DATA_W+PAR_W, the highest Hamming position. CW = N+1, the codeword width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_vld  in  1  input codeword valid.
- i_rdy  out  1  decoder accepts input this cycle.
- i_code  in  CW  received codeword. Bit 0 = overall parity; bit p (1..N) = Hamming position p.
- corr_en  in  1  1: correct single errors; 0: flag only, pass data raw.
- o_vld  out  1  output valid.
- o_rdy  in  1  downstream accepts output.
- o_data  out  DATA_W  decoded data.
- o_sec  out  1  single error detected (corrected when corr_en=1).
- o_ded  out  1  uncorrectable error detected.
- o_syn  out  PAR_W  Hamming syndrome of this word.
- cnt_clr  in  1  synchronous clear of both counters.
- sec_cnt  out  CNT_W  saturating count of delivered words with o_sec=1.
- ded_cnt  out  CNT_W  saturating count of delivered words with o_ded=1.

Behaviour:
- Codeword layout:
  - Check bit j sits at position 2^j.
  - Data bit k sits at the k-th non-power-of-two position, ascending (data[0] at position 3, data[1] at 5, ...).
  - Bit 0 makes the XOR of all CW bits even.
- Stage 1 registers:
  - raw word;
  - syndrome s = XOR over p=1..N of (p if i_code[p]);
  - P = XOR of all CW bits;
  - corr_en, sampled with the word.
- Stage 2 decode, in priority order:
  - s==0, P==0: clean. sec=0, ded=0.
  - P==1, s<=N: sec=1. If s!=0 and corr_en=1, flip bit s before data extraction. If s==0, only the parity bit was wrong; data is unchanged.
  - P==1, s>N: ded=1.
  - P==0, s!=0: ded=1.
  - When ded=1, o_data = raw extracted data.
- o_syn = s in every case.
- Latency: an accepted word appears on o_vld exactly 2 cycles later when there is no backpressure. Throughput is 1 word/cycle.
- Flow control:
  - en2 = ~o_vld | o_rdy.
  - en1 = ~s1_vld | en2.
  - i_rdy = en1 (combinational from o_rdy).
  - Words are never dropped, duplicated or reordered.
  - Outputs hold stable while o_vld=1 and o_rdy=0.
- Counters:
  - Increment only on the output handshake (o_vld & o_rdy), so each word is counted once.
  - Saturate at all-ones.
  - cnt_clr has priority: a handshake event in the same cycle is discarded and the counter reads 0.
- Reset: all pipeline valids, o_data, o_sec, o_ded, o_syn, sec_cnt and ded_cnt go to 0; i_rdy reads 1. Reset mid-operation discards in-flight words.
- Input data and flags are don't-care when the matching valid is 0. Register enables must gate them so outputs do not toggle on idle cycles.

Test Plan:
1. Clean word, data 0x12345678 encoded, o_rdy=1 -> o_vld 2 cycles later, o_data=0x12345678, o_sec=0, o_ded=0, o_syn=0.
2. Same word with position 5 flipped, corr_en=1 -> o_data=0x12345678, o_sec=1, o_syn=5, sec_cnt=1. Bit 0 flipped -> o_sec=1, o_syn=0, data unchanged.
3. Positions 3 and 10 flipped -> o_ded=1, o_syn=9, o_data = raw extracted data, ded_cnt +1. Repeat single error with corr_en=0 -> o_sec=1, o_data carries the flipped bit.
4. Stream 4 words, o_rdy held low 5 cycles from the first o_vld -> i_rdy low after 2 words are accepted, outputs stable, all 4 words delivered in order once o_rdy returns.
5. CNT_W=4, 20 single-error words -> sec_cnt=15. Then assert cnt_clr together with a SEC handshake -> sec_cnt=0.
6. rst_n low for 1 cycle with 2 words in flight -> o_vld=0, counters 0, i_rdy=1; the next word decodes normally with 2-cycle latency.
